// File: rtl/datamem_lsu_pkg.sv
// Shared definitions for the RV32I data memory with load/store alignment:
// funct3 codes, FSM states and the byte-mask / access-error helpers.
package datamem_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  function automatic logic [3:0] byte_mask(input logic [2:0] funct3, input logic [1:0] off);
    logic [3:0] mask;
    mask = 4'b0000;
    case (funct3)
      F3_B:    mask = 4'b0001 << off;
      F3_H:    mask = off[1] ? 4'b1100 : 4'b0011;
      F3_W:    mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

  // Unsigned codes are load-only; 011/110/111 are never legal.
  function automatic logic access_err(input logic we, input logic [2:0] funct3,
                                      input logic [1:0] off);
    logic err;
    err = 1'b0;
    case (funct3)
      F3_B:    err = 1'b0;
      F3_H:    err = off[0];
      F3_W:    err = (off != 2'b00);
      F3_BU:   err = we;
      F3_HU:   err = we | off[0];
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/datamem_lsu_align.sv
// Load lane extraction with sign/zero extension; purely combinational so the
// core's forwarding path can share it.
module datamem_lsu_align
  import datamem_lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] rdata_o
);

  logic [7:0]  lane_b_s;
  logic [15:0] lane_h_s;

  always_comb begin
    lane_b_s = 8'h00;
    case (off_i)
      2'b00:   lane_b_s = word_i[7:0];
      2'b01:   lane_b_s = word_i[15:8];
      2'b10:   lane_b_s = word_i[23:16];
      2'b11:   lane_b_s = word_i[31:24];
      default: lane_b_s = 8'h00;
    endcase
    if (off_i[1]) begin
      lane_h_s = word_i[31:16];
    end else begin
      lane_h_s = word_i[15:0];
    end
  end

  always_comb begin
    rdata_o = word_i;
    case (funct3_i)
      F3_B:    rdata_o = {{24{lane_b_s[7]}}, lane_b_s};
      F3_BU:   rdata_o = {24'h000000, lane_b_s};
      F3_H:    rdata_o = {{16{lane_h_s[15]}}, lane_h_s};
      F3_HU:   rdata_o = {16'h0000, lane_h_s};
      F3_W:    rdata_o = word_i;
      default: rdata_o = word_i;
    endcase
  end

endmodule

// File: rtl/datamem_lsu.sv
// RV32I data memory: zeroing init sequencer, byte-masked stores, synchronous
// reads and a READ_LATENCY-deep response pipeline ending in the align unit.
module datamem_lsu
  import datamem_lsu_pkg::*;
#(
  parameter int ADDR_W       = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int LAST  = READ_LATENCY - 1;

  logic [31:0]       mem_q [DEPTH];

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
  logic              ready_q, ready_d;

  logic              accept_s;
  logic              err_s;
  logic              load_ok_s;
  logic [3:0]        mask_s;
  logic [ADDR_W-1:0] widx_s;
  logic [31:0]       wdata_rep_s;

  logic [READ_LATENCY-1:0] v_q;
  logic [READ_LATENCY-1:0] err_q;
  logic [31:0]             w_q   [READ_LATENCY];
  logic [1:0]              off_q [READ_LATENCY];
  logic [2:0]              f3_q  [READ_LATENCY];

  always_comb begin
    accept_s    = req_valid & ready_q;
    err_s       = access_err(req_we, req_funct3, req_addr[1:0]);
    load_ok_s   = accept_s & ~req_we & ~err_s;
    mask_s      = byte_mask(req_funct3, req_addr[1:0]);
    widx_s      = req_addr[ADDR_W+1:2];
    wdata_rep_s = 32'h0000_0000;
    case (req_funct3)
      F3_B:    wdata_rep_s = {4{req_wdata[7:0]}};
      F3_H:    wdata_rep_s = {2{req_wdata[15:0]}};
      default: wdata_rep_s = req_wdata;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    case (state_q)
      ST_INIT: begin
        init_cnt_d = init_cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        if (init_cnt_q == {ADDR_W{1'b1}}) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_INIT;
        end
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
    ready_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      init_cnt_q <= {ADDR_W{1'b0}};
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      ready_q    <= ready_d;
    end
  end

  // Array contents are never reset; INIT zeroes them word by word instead.
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      mem_q[init_cnt_q] <= 32'h0000_0000;
    end else if (accept_s && req_we && !err_s) begin
      for (int b = 0; b < 4; b++) begin
        if (mask_s[b]) begin
          mem_q[widx_s][8*b +: 8] <= wdata_rep_s[8*b +: 8];
        end
      end
    end
  end

  // Stores and errors carry a zero word so the final stage yields rdata 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q   <= '0;
      err_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        w_q[i]   <= 32'h0000_0000;
        off_q[i] <= 2'b00;
        f3_q[i]  <= 3'b000;
      end
    end else begin
      v_q[0] <= accept_s;
      if (accept_s) begin
        w_q[0]   <= load_ok_s ? mem_q[widx_s] : 32'h0000_0000;
        off_q[0] <= req_addr[1:0];
        f3_q[0]  <= req_funct3;
        err_q[0] <= err_s;
      end
      for (int i = 1; i < READ_LATENCY; i++) begin
        v_q[i] <= v_q[i-1];
        if (v_q[i-1]) begin
          w_q[i]   <= w_q[i-1];
          off_q[i] <= off_q[i-1];
          f3_q[i]  <= f3_q[i-1];
          err_q[i] <= err_q[i-1];
        end
      end
    end
  end

  datamem_lsu_align u_align (
    .word_i   (w_q[LAST]),
    .off_i    (off_q[LAST]),
    .funct3_i (f3_q[LAST]),
    .rdata_o  (rsp_rdata)
  );

  assign req_ready = ready_q;
  assign rsp_valid = v_q[LAST];
  assign rsp_err   = err_q[LAST];

endmodule

// File: tb/tb_datamem_lsu.sv
// Directed bench: a latency-1 and a latency-3 instance share one request stream.
module tb_datamem_lsu;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;

  logic        req_ready1, rsp_valid1, rsp_err1;
  logic [31:0] rsp_rdata1;
  logic        req_ready3, rsp_valid3, rsp_err3;
  logic [31:0] rsp_rdata3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  datamem_lsu #(.ADDR_W(8), .READ_LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready1),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1));

  datamem_lsu #(.ADDR_W(8), .READ_LATENCY(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready3),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid3), .rsp_rdata(rsp_rdata3), .rsp_err(rsp_err3));

  // One request accepted on the next edge; dut1 response sampled 1 ns later.
  task automatic req1(input logic we, input logic [2:0] f3, input logic [9:0] addr,
                      input logic [31:0] wdata, output logic v, output logic [31:0] d,
                      output logic e);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    v = rsp_valid1; d = rsp_rdata1; e = rsp_err1;
  endtask

  task automatic wait_ready(output int n, output logic any_rsp);
    n = 0;
    any_rsp = 1'b0;
    while (!req_ready1 && n < 1000) begin
      any_rsp = any_rsp | rsp_valid1 | rsp_valid3;
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    int n;
    logic any;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 10'h000; req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    checks++;
    if ({req_ready1, rsp_valid1, rsp_err1} !== 3'b000 || rsp_rdata1 !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: got ready=%b valid=%b err=%b rdata=%h expected 0/0/0/0",
               req_ready1, rsp_valid1, rsp_err1, rsp_rdata1);
    end
    rst_n = 1'b1;
    wait_ready(n, any);
    checks++;
    if (n !== 256 || req_ready1 !== 1'b1) begin
      errors++;
      $display("FAIL init_length: got %0d not-ready cycles (ready=%b) expected 256", n, req_ready1);
    end
  endtask

  task automatic test_init_zero;
    logic v, e;
    logic [31:0] d;
    req1(1'b0, 3'b010, 10'h3FC, 32'h0, v, d, e);
    checks++;
    if (v !== 1'b1 || d !== 32'h0 || e !== 1'b0) begin
      errors++;
      $display("FAIL lw_3fc_zero: got v=%b d=%h e=%b expected 1 00000000 0", v, d, e);
    end
  endtask

  task automatic test_store_load;
    logic v, e;
    logic [31:0] d;
    logic [2:0]  f3s  [5] = '{3'b010, 3'b000, 3'b100, 3'b001, 3'b101};
    logic [9:0]  adrs [5] = '{10'h010, 10'h013, 10'h013, 10'h012, 10'h010};
    logic [31:0] exps [5] = '{32'hDEADBEEF, 32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000BEEF};
    req1(1'b1, 3'b010, 10'h010, 32'hDEADBEEF, v, d, e);
    checks++;
    if (v !== 1'b1 || d !== 32'h0 || e !== 1'b0) begin
      errors++;
      $display("FAIL sw_rsp: got v=%b d=%h e=%b expected 1 00000000 0", v, d, e);
    end
    for (int i = 0; i < 5; i++) begin
      req1(1'b0, f3s[i], adrs[i], 32'h0, v, d, e);
      checks++;
      if (v !== 1'b1 || d !== exps[i] || e !== 1'b0) begin
        errors++;
        $display("FAIL load_%0d: got v=%b d=%h e=%b expected 1 %h 0", i, v, d, e, exps[i]);
      end
    end
  endtask

  task automatic test_partial;
    logic v, e;
    logic [31:0] d;
    req1(1'b1, 3'b000, 10'h011, 32'hAAAAAA55, v, d, e);
    req1(1'b1, 3'b001, 10'h012, 32'hBBBB1234, v, d, e);
    req1(1'b0, 3'b010, 10'h010, 32'h0, v, d, e);
    checks++;
    if (d !== 32'h123455EF || e !== 1'b0) begin
      errors++;
      $display("FAIL partial_lw: got d=%h e=%b expected 123455ef 0", d, e);
    end
    req1(1'b0, 3'b000, 10'h011, 32'h0, v, d, e);
    checks++;
    if (d !== 32'h00000055) begin
      errors++;
      $display("FAIL lb_positive: got %h expected 00000055", d);
    end
  endtask

  task automatic test_misalign;
    logic v, e;
    logic [31:0] d;
    req1(1'b1, 3'b010, 10'h012, 32'hFFFFFFFF, v, d, e);
    checks++;
    if (v !== 1'b1 || e !== 1'b1 || d !== 32'h0) begin
      errors++;
      $display("FAIL sw_misalign: got v=%b e=%b d=%h expected 1 1 00000000", v, e, d);
    end
    req1(1'b1, 3'b100, 10'h010, 32'hFFFFFFFF, v, d, e);
    checks++;
    if (e !== 1'b1) begin
      errors++;
      $display("FAIL store_f3_100: got err=%b expected 1", e);
    end
    req1(1'b0, 3'b010, 10'h010, 32'h0, v, d, e);
    checks++;
    if (d !== 32'h123455EF || e !== 1'b0) begin
      errors++;
      $display("FAIL mem_unchanged: got d=%h e=%b expected 123455ef 0", d, e);
    end
    req1(1'b0, 3'b001, 10'h011, 32'h0, v, d, e);
    checks++;
    if (e !== 1'b1 || d !== 32'h0) begin
      errors++;
      $display("FAIL lh_misalign: got e=%b d=%h expected 1 00000000", e, d);
    end
    req1(1'b0, 3'b011, 10'h010, 32'h0, v, d, e);
    checks++;
    if (e !== 1'b1 || d !== 32'h0) begin
      errors++;
      $display("FAIL f3_011: got e=%b d=%h expected 1 00000000", e, d);
    end
  endtask

  task automatic test_back_to_back;
    logic v, e;
    logic [31:0] d;
    for (int i = 0; i < 4; i++) begin
      req1(1'b1, 3'b010, 10'(4*i), 32'(i+1), v, d, e);
    end
    repeat (4) @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 10'h000;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (c < 3) begin
        req_addr = 10'(4*(c+1));
      end else begin
        req_valid = 1'b0;
      end
      checks++;
      if (rsp_valid3 !== (c >= 2 && c <= 5)) begin
        errors++;
        $display("FAIL pipe_valid_c%0d: got %b expected %b", c, rsp_valid3, (c >= 2 && c <= 5));
      end else if (c >= 2 && c <= 5 && rsp_rdata3 !== 32'(c-1)) begin
        errors++;
        $display("FAIL pipe_data_c%0d: got %h expected %h", c, rsp_rdata3, 32'(c-1));
      end
    end
  endtask

  task automatic test_reset_midstream;
    logic v, e, any;
    logic [31:0] d;
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 10'h010;
    @(posedge clk); #1;
    req_addr = 10'h014;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_n = 1'b0;
    any = 1'b0;
    repeat (4) begin
      @(negedge clk);
      any = any | rsp_valid3;
    end
    rst_n = 1'b1;
    checks++;
    if (any !== 1'b0) begin
      errors++;
      $display("FAIL inflight_dropped: got rsp_valid=%b during reset expected 0", any);
    end
    wait_ready(n, any);
    checks++;
    if (n !== 256 || any !== 1'b0) begin
      errors++;
      $display("FAIL reinit: got %0d cycles rsp_seen=%b expected 256 0", n, any);
    end
    req1(1'b0, 3'b010, 10'h010, 32'h0, v, d, e);
    checks++;
    if (v !== 1'b1 || d !== 32'h0 || e !== 1'b0) begin
      errors++;
      $display("FAIL rezeroed: got v=%b d=%h e=%b expected 1 00000000 0", v, d, e);
    end
  endtask

  initial begin
    test_reset();
    test_init_zero();
    test_store_load();
    test_partial();
    test_misalign();
    test_back_to_back();
    test_reset_midstream();
    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
